tensor_core_scheduler: RTL and testbench
========================================

TENSOR_CORE_SCHEDULER -- requirements
Module: tensor_core_scheduler

Interface
REQ-001 Parameter BUS_WIDTH, default 8, sets the signed matrix element width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, sets the maximum number of COMPUTE cycles before the job is aborted.
REQ-003 Port clock_in, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_in, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req_valid, input, [2]: requester i presents a job.
REQ-006 Port req_ready, output, [2]: job from requester i is accepted this cycle.
REQ-007 Port req_input1, input, [2][4][4] x BUS_WIDTH signed: operand A per requester.
REQ-008 Port req_input2, input, [2][4][4] x BUS_WIDTH signed: operand B per requester.
REQ-009 Port resp_valid, output, 1 bit: result available.
REQ-010 Port resp_ready, input, 1 bit: consumer takes the result.
REQ-011 Port resp_id, output, 1 bit: index of the requester that owns the result.
REQ-012 Port resp_data, output, [4][4] x BUS_WIDTH signed: product matrix A*B.
REQ-013 Port resp_timeout, output, 1 bit: the job was aborted; resp_data is all zero.
REQ-014 Port tensor_core_register_file_write_enable, output, 1 bit: load/restart strobe to the core.
REQ-015 Port tensor_core_input1, output, [4][4] x BUS_WIDTH signed: latched operand A driven to the core.
REQ-016 Port tensor_core_input2, output, [4][4] x BUS_WIDTH signed: latched operand B driven to the core.
REQ-017 Port tensor_core_output, input, [4][4] x BUS_WIDTH signed: core result.
REQ-018 Port is_done_with_calculation, input, 1 bit: core completion flag.
REQ-019 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, COMPUTE and RESPOND, encoded internally.
REQ-021 IDLE SHALL assert req_ready for the arbitration winner only, combinationally; accept = req_valid[i] && req_ready[i]; on accept go to LOAD.
REQ-022 Arbitration SHALL be round-robin: with one valid requester, grant it; with both valid, grant the index != last_grant; last_grant updates on accept only.
REQ-023 On accept, the block SHALL register the winner's req_input1/req_input2 and its id; tensor_core_input1/2 SHALL hold these registers unchanged until the next accept.
REQ-024 LOAD SHALL last exactly 1 cycle with tensor_core_register_file_write_enable=1, then go to COMPUTE; write enable SHALL be 0 in every other state.
REQ-025 COMPUTE SHALL ignore is_done_with_calculation in its first cycle (stale flag) and sample it from the second cycle onward.
REQ-026 When done is sampled high, the block SHALL register tensor_core_output into resp_data, set resp_timeout=0 and go to RESPOND.
REQ-027 A cycle counter SHALL clear on entry to COMPUTE; when it reaches TIMEOUT_CYCLES without done, the block SHALL set resp_data=0 and resp_timeout=1 and go to RESPOND.
REQ-028 RESPOND SHALL hold resp_valid=1 with resp_data, resp_id and resp_timeout stable until resp_ready=1; on that cycle go to IDLE.
REQ-029 req_ready SHALL be 0 outside IDLE; no request is accepted in the cycle the response is consumed.
REQ-030 Result elements SHALL be passed through at BUS_WIDTH bits with no re-truncation or sign change.
REQ-031 Minimum accept-to-resp_valid latency SHALL be 3 cycles (LOAD, COMPUTE x2).

Reset
REQ-032 While reset_in=1 at a rising edge: state=IDLE, last_grant=1 (requester 0 wins first), counter=0, operand and result registers=0, id=0.
REQ-033 While in reset: resp_valid=0, resp_timeout=0, write enable=0, busy=0 and req_ready=0.
REQ-034 Reset mid-job SHALL drop the job silently; no response is produced for it.

Verification
REQ-035 A=identity, B[i][j]=i*4+j from requester 0 -> resp_data=B, resp_id=0, resp_timeout=0, resp_valid 3 or more cycles after accept.
REQ-036 Both req_valid high from reset -> requester 0 served first, then requester 1; two responses with ids 0 then 1; write enable pulses exactly twice.
REQ-037 resp_ready held low 5 cycles in RESPOND -> resp_valid, resp_data and resp_id stable throughout; req_ready=0 throughout.
REQ-038 is_done_with_calculation tied low -> after TIMEOUT_CYCLES in COMPUTE: resp_valid=1, resp_timeout=1, resp_data all 0.
REQ-039 reset_in pulsed in COMPUTE -> next cycle busy=0, resp_valid=0, write enable=0; a new job then completes normally.
REQ-040 A all 2s, B all 1s with BUS_WIDTH=8 -> every resp_data element=8; A all -1s, B all 1s -> every element=-4.

Source files
------------

// File: rtl/tensor_core_scheduler_if.sv
// ---------------------------------------------------------------------------
// tensor_core_scheduler_if
//
// Groups the request, response and tensor-core signals of the scheduler.
//
// Handshake rules (valid/ready, shared by the request and response channels):
//   - A transfer happens on a rising clock edge where valid and ready are both 1.
//   - valid does not wait for ready. Once the scheduler raises resp_valid, it
//     holds resp_valid and the response fields stable until the transfer.
//   - req_ready is driven combinationally from req_valid. At most one bit of
//     req_ready is ever high, and only for the arbitration winner.
//
// Modports:
//   slave  - the scheduler. It takes requests, produces responses and drives
//            the core operands.
//   master - the environment. It is made up of the requesters, the response
//            consumer and the tensor core.
//
// Signal summary:
//   req_valid[1:0], req_ready[1:0]    per-requester job handshake
//   req_input1/2[1:0]                 per-requester 4x4 operands A and B
//   resp_valid, resp_ready            result handshake
//   resp_id, resp_data, resp_timeout  result owner, 4x4 product, abort flag
//   tensor_core_*                     operand/strobe/result link to the core
//   is_done_with_calculation          core completion flag
// ---------------------------------------------------------------------------
interface tensor_core_scheduler_if #(
  parameter int BUS_WIDTH = 8
);
  logic [1:0]                                    req_valid;
  logic [1:0]                                    req_ready;
  logic signed [1:0][3:0][3:0][BUS_WIDTH-1:0]   req_input1;
  logic signed [1:0][3:0][3:0][BUS_WIDTH-1:0]   req_input2;

  logic                                          resp_valid;
  logic                                          resp_ready;
  logic                                          resp_id;
  logic signed [3:0][3:0][BUS_WIDTH-1:0]        resp_data;
  logic                                          resp_timeout;

  logic                                          tensor_core_register_file_write_enable;
  logic signed [3:0][3:0][BUS_WIDTH-1:0]        tensor_core_input1;
  logic signed [3:0][3:0][BUS_WIDTH-1:0]        tensor_core_input2;
  logic signed [3:0][3:0][BUS_WIDTH-1:0]        tensor_core_output;
  logic                                          is_done_with_calculation;

  modport slave (
    input  req_valid, req_input1, req_input2, resp_ready,
           tensor_core_output, is_done_with_calculation,
    output req_ready, resp_valid, resp_id, resp_data, resp_timeout,
           tensor_core_register_file_write_enable,
           tensor_core_input1, tensor_core_input2
  );

  modport master (
    output req_valid, req_input1, req_input2, resp_ready,
           tensor_core_output, is_done_with_calculation,
    input  req_ready, resp_valid, resp_id, resp_data, resp_timeout,
           tensor_core_register_file_write_enable,
           tensor_core_input1, tensor_core_input2
  );
endinterface

// File: rtl/tensor_core_scheduler.sv
// ---------------------------------------------------------------------------
// tensor_core_scheduler
//
// This block serves 4x4 matrix-multiply jobs from two requesters on a single
// external tensor core.
//
// Job flow:
//   1. IDLE: a round-robin arbiter picks one valid requester.
//   2. On acceptance, the winner's operands are latched.
//   3. LOAD: the operands are strobed into the core for one cycle.
//   4. COMPUTE: the block waits for the core's done flag, bounded by
//      TIMEOUT_CYCLES.
//   5. RESPOND: the result, or an all-zero timeout response, is presented to
//      the consumer.
//
// Ports:
//   clock_in   rising-edge clock
//   reset_in   synchronous, active-high reset
//   bus        tensor_core_scheduler_if.slave (request, response, core link)
//   busy       high whenever the FSM is not in IDLE
//   dbg_state  current FSM state, for observation only
//              0 = IDLE, 1 = LOAD, 2 = COMPUTE, 3 = RESPOND
// ---------------------------------------------------------------------------
module tensor_core_scheduler #(
  parameter int BUS_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  tensor_core_scheduler_if.slave    bus,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  typedef logic signed [3:0][3:0][BUS_WIDTH-1:0] mat_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mat_t             op_a_q, op_a_d;
  mat_t             op_b_q, op_b_d;
  mat_t             result_q, result_d;
  logic             id_q, id_d;
  logic             timeout_q, timeout_d;

  logic             any_valid;
  logic             winner;
  logic [1:0]       grant;
  logic             accept;

  // -------------------------------------------------------------------------
  // Round-robin arbitration.
  // When both requesters are valid, the one not served last time wins.
  // When only one is valid, it wins.
  // The grant is only offered in IDLE and never while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    any_valid = |bus.req_valid;
    if (&bus.req_valid) begin
      winner = ~last_grant_q;
    end else begin
      winner = ~bus.req_valid[0];
    end
    grant = 2'b00;
    if ((state_q == S_IDLE) && any_valid && !reset_in) begin
      grant[winner] = 1'b1;
    end
    accept = |(grant & bus.req_valid);
  end

  // -------------------------------------------------------------------------
  // Next-state logic and register updates.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    id_d         = id_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d       = bus.req_input1[winner];
          op_b_d       = bus.req_input2[winner];
          id_d         = winner;
          last_grant_d = winner;
          state_d      = S_LOAD;
        end
      end

      S_LOAD: begin
        // Clearing here means the counter reads zero in the first COMPUTE cycle.
        cnt_d   = '0;
        state_d = S_COMPUTE;
      end

      S_COMPUTE: begin
        // In the first COMPUTE cycle (cnt_q == 0) the done flag may still be
        // left over from the previous job, so it is not trusted until the
        // core has seen the new write strobe.
        if ((cnt_q != '0) && bus.is_done_with_calculation) begin
          result_d  = bus.tensor_core_output;
          timeout_d = 1'b0;
          state_d   = S_RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = S_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESPOND: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      id_q         <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      id_q         <= id_d;
      timeout_q    <= timeout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs.
  // The status outputs are also gated by reset_in, so they read 0 for the
  // whole time reset is held. This includes the cycles before the first
  // reset edge has cleared the registers.
  // -------------------------------------------------------------------------
  assign bus.req_ready    = grant;
  assign bus.resp_valid   = (state_q == S_RESPOND) && !reset_in;
  assign bus.resp_id      = id_q;
  assign bus.resp_data    = result_q;
  assign bus.resp_timeout = timeout_q && !reset_in;

  assign bus.tensor_core_register_file_write_enable = (state_q == S_LOAD) && !reset_in;
  assign bus.tensor_core_input1 = op_a_q;
  assign bus.tensor_core_input2 = op_b_q;

  assign busy      = (state_q != S_IDLE) && !reset_in;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tensor_core_scheduler
//
// Self-checking bench for tensor_core_scheduler.
//
// A behavioural tensor core answers each write strobe with the matrix product
// after a chosen number of cycles. A latency of zero means the core never
// finishes.
//
// Expected responses come from a plain integer 4x4 multiply. The expected
// latency comes from the job timeline: one LOAD cycle, then at least two
// COMPUTE cycles.
// ---------------------------------------------------------------------------
module tb_tensor_core_scheduler;
  localparam int BW = 8;
  localparam int TO = 20;
  localparam int W  = 2 + 16 * BW;

  typedef logic [3:0][3:0][BW-1:0] mat_t;

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic       busy;
  logic [1:0] dbg_state;

  tensor_core_scheduler_if #(.BUS_WIDTH(BW)) bus();

  tensor_core_scheduler #(.BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---- clock ----
  always #5 clock_in = ~clock_in;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // ---- reference model: plain signed 4x4 multiply, wrapped to BW bits ----
  function automatic mat_t ref_mul(input mat_t a, input mat_t b);
    mat_t r;
    int   s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        end
        r[i][j] = s[BW-1:0];
      end
    end
    return r;
  endfunction

  function automatic mat_t fill(input int v);
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = BW'(v);
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = BW'($urandom_range(0, (1 << BW) - 1));
    return m;
  endfunction

  // ---- behavioural tensor core ----
  int   core_lat = 1;
  int   core_cnt;
  int   we_count = 0;
  mat_t core_a, core_b;

  always @(posedge clock_in) begin
    if (reset_in) begin
      core_cnt                     <= 0;
      bus.is_done_with_calculation <= 1'b0;
      bus.tensor_core_output       <= '0;
    end else if (bus.tensor_core_register_file_write_enable) begin
      core_a                       <= bus.tensor_core_input1;
      core_b                       <= bus.tensor_core_input2;
      bus.is_done_with_calculation <= 1'b0;
      core_cnt                     <= core_lat;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      bus.tensor_core_output       <= ref_mul(core_a, core_b);
      bus.is_done_with_calculation <= 1'b1;
      core_cnt                     <= 0;
    end
    if (bus.tensor_core_register_file_write_enable) we_count <= we_count + 1;
  end

  // ---- driver tasks (all start and end on a falling edge) ----
  task automatic do_reset();
    reset_in      = 1'b1;
    bus.req_valid = 2'b00;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clock_in);
    reset_in = 1'b0;
  endtask

  task automatic send_job(input int id, input mat_t a, input mat_t b, output bit ok);
    bus.req_input1[id] = a;
    bus.req_input2[id] = b;
    bus.req_valid[id]  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      #1;
      if (bus.req_ready[id]) ok = 1'b1;
      @(negedge clock_in);
    end
    bus.req_valid[id] = 1'b0;
  endtask

  // lat counts rising edges from the accepting edge up to resp_valid.
  task automatic wait_resp(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      if (bus.resp_valid === 1'b1) got = 1'b1;
      else begin
        @(negedge clock_in);
        lat++;
      end
    end
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    @(negedge clock_in);
    bus.resp_ready = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    reset_in       = 1'b1;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 1'b0;
    bus.req_input1 = '0;
    bus.req_input2 = '0;
    repeat (3) @(negedge clock_in);
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.resp_timeout !== 1'b0) begin bad++; $display("FAIL reset_resp_timeout got=%b exp=0", bus.resp_timeout); end
    total++; if (bus.tensor_core_register_file_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.tensor_core_register_file_write_enable); end
    bus.req_valid = 2'b00;
    reset_in = 1'b0;
    @(negedge clock_in);
    total++; if (bus.resp_data !== '0 || bus.tensor_core_input1 !== '0 || bus.tensor_core_input2 !== '0) begin
      bad++; $display("FAIL reset_regs got=%h/%h/%h exp=0", bus.resp_data, bus.tensor_core_input1, bus.tensor_core_input2);
    end
  endtask

  task automatic test_identity();
    mat_t a, b;
    int   lat, we0;
    bit   ok, got;
    a = '0;
    for (int i = 0; i < 4; i++) a[i][i] = BW'(1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) b[i][j] = BW'(i * 4 + j);
    core_lat = 1;
    we0 = we_count;
    send_job(0, a, b, ok);
    total++; if (!ok) begin bad++; $display("FAIL identity_accept got=0 exp=1"); end
    wait_resp(lat, got);
    total++; if (!got || lat != 3) begin bad++; $display("FAIL identity_latency got=%0d exp=3", lat); end
    total++; if (bus.resp_data !== b) begin bad++; $display("FAIL identity_data got=%h exp=%h", bus.resp_data, b); end
    total++; if (bus.resp_id !== 1'b0 || bus.resp_timeout !== 1'b0) begin
      bad++; $display("FAIL identity_flags got=id%b/to%b exp=id0/to0", bus.resp_id, bus.resp_timeout);
    end
    consume();
    total++; if (we_count - we0 != 1) begin bad++; $display("FAIL identity_we_pulses got=%0d exp=1", we_count - we0); end
  endtask

  task automatic test_values();
    int   lat;
    bit   ok, got;
    mat_t a, e;
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? fill(2) : fill(-1);
      e = (t == 0) ? fill(8) : fill(-4);
      core_lat = 2;
      send_job(1, a, fill(1), ok);
      wait_resp(lat, got);
      total++; if (!got || bus.resp_data !== e) begin
        bad++; $display("FAIL values_%0d got=%h exp=%h", t, bus.resp_data, e);
      end
      consume();
    end
  endtask

  task automatic test_arbitration();
    mat_t a0, b0, a1, b1;
    int   lat, we0;
    bit   got;
    do_reset();
    a0 = rand_mat(); b0 = rand_mat(); a1 = rand_mat(); b1 = rand_mat();
    core_lat = 2;
    we0 = we_count;
    bus.req_input1[0] = a0; bus.req_input2[0] = b0;
    bus.req_input1[1] = a1; bus.req_input2[1] = b1;
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL arb_first_grant got=%b exp=01", bus.req_ready); end
    @(negedge clock_in);
    bus.req_valid[0] = 1'b0;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL arb_busy_ready got=%b exp=00", bus.req_ready); end
    wait_resp(lat, got);
    total++; if (!got || bus.resp_id !== 1'b0 || bus.resp_data !== ref_mul(a0, b0)) begin
      bad++; $display("FAIL arb_resp0 got=id%b %h exp=id0 %h", bus.resp_id, bus.resp_data, ref_mul(a0, b0));
    end
    consume();
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL arb_second_grant got=%b exp=10", bus.req_ready); end
    @(negedge clock_in);
    bus.req_valid[1] = 1'b0;
    wait_resp(lat, got);
    total++; if (!got || bus.resp_id !== 1'b1 || bus.resp_data !== ref_mul(a1, b1)) begin
      bad++; $display("FAIL arb_resp1 got=id%b %h exp=id1 %h", bus.resp_id, bus.resp_data, ref_mul(a1, b1));
    end
    consume();
    total++; if (we_count - we0 != 2) begin bad++; $display("FAIL arb_we_pulses got=%0d exp=2", we_count - we0); end
    // Requester 1 was served last, so requester 0 wins the next tie.
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL arb_rotate got=%b exp=01", bus.req_ready); end
    bus.req_valid = 2'b00;
    @(negedge clock_in);
  endtask

  task automatic test_backpressure();
    mat_t a, b, e;
    int   lat, stable_errs;
    bit   ok, got;
    a = rand_mat(); b = rand_mat(); e = ref_mul(a, b);
    core_lat = 1;
    send_job(0, a, b, ok);
    bus.req_valid[1] = 1'b1;
    wait_resp(lat, got);
    total++; if (!got) begin bad++; $display("FAIL bp_no_resp got=0 exp=1"); end
    stable_errs = 0;
    for (int h = 0; h < 5; h++) begin
      @(negedge clock_in);
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== e || bus.resp_id !== 1'b0 || bus.req_ready !== 2'b00)
        stable_errs++;
    end
    total++; if (stable_errs != 0) begin
      bad++; $display("FAIL bp_stable got=%0d unstable cycles exp=0 (v=%b id=%b rdy=%b)", stable_errs, bus.resp_valid, bus.resp_id, bus.req_ready);
    end
    bus.req_valid[1] = 1'b0;
    consume();
  endtask

  task automatic test_timeout();
    int lat;
    bit ok, got;
    core_lat = 0;
    send_job(1, rand_mat(), rand_mat(), ok);
    wait_resp(lat, got);
    total++; if (!got || lat != 1 + TO) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, 1 + TO); end
    total++; if (bus.resp_timeout !== 1'b1 || bus.resp_data !== '0 || bus.resp_id !== 1'b1) begin
      bad++; $display("FAIL timeout_resp got=to%b id%b %h exp=to1 id1 0", bus.resp_timeout, bus.resp_id, bus.resp_data);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    mat_t a, b;
    int   lat, spurious;
    bit   ok, got;
    core_lat = 0;
    send_job(0, rand_mat(), rand_mat(), ok);
    repeat (3) @(negedge clock_in);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    reset_in = 1'b1;
    @(negedge clock_in);
    reset_in = 1'b0;
    total++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.tensor_core_register_file_write_enable !== 1'b0) begin
      bad++; $display("FAIL rstmid_after got=busy%b v%b we%b exp=000", busy, bus.resp_valid, bus.tensor_core_register_file_write_enable);
    end
    spurious = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.resp_valid !== 1'b0 || busy !== 1'b0) spurious++;
      @(negedge clock_in);
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL rstmid_dropped got=%0d exp=0", spurious); end
    a = rand_mat(); b = rand_mat();
    core_lat = 2;
    send_job(0, a, b, ok);
    wait_resp(lat, got);
    total++; if (!got || lat != 4 || bus.resp_data !== ref_mul(a, b) || bus.resp_timeout !== 1'b0) begin
      bad++; $display("FAIL rstmid_new_job got=lat%0d %h exp=lat4 %h", lat, bus.resp_data, ref_mul(a, b));
    end
    consume();
  endtask

  task automatic test_random();
    mat_t a, b;
    int   id, lat, exp_lat, errs;
    bit   ok, got;
    logic [W-1:0] e;
    errs = 0;
    for (int n = 0; n < 24; n++) begin
      id = $urandom_range(0, 1);
      core_lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
      a = rand_mat(); b = rand_mat();
      if (core_lat == 0) begin
        exp_q.push_back({id[0], 1'b1, mat_t'('0)});
        exp_lat = 1 + TO;
      end else begin
        exp_q.push_back({id[0], 1'b0, ref_mul(a, b)});
        exp_lat = 2 + core_lat;
      end
      send_job(id, a, b, ok);
      wait_resp(lat, got);
      e = exp_q.pop_front();
      total++;
      if (!ok || !got || lat != exp_lat || {bus.resp_id, bus.resp_timeout, bus.resp_data} !== e) begin
        bad++; errs++;
        $display("FAIL random_%0d got=lat%0d %h exp=lat%0d %h", n, lat, {bus.resp_id, bus.resp_timeout, bus.resp_data}, exp_lat, e);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock_in);
      consume();
    end
  endtask

  // ---- sequence and report ----
  initial begin
    test_reset();
    test_identity();
    test_values();
    test_arbitration();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
